// File: rtl/noc_packetizer.sv
// Injection-side packetizer: wraps an AXI-Stream message from the local core into
// router packets (header flit + payload flits), splitting long messages into continuations.
module noc_packetizer #(
  parameter int DATA_WIDTH    = 32,
  parameter int MAX_ROUTERS_X = 4,
  parameter int MAX_ROUTERS_Y = 4,
  parameter int ROUTER_X      = 0,
  parameter int ROUTER_Y      = 0,
  parameter int MAX_PAYLOAD   = 4,
  parameter int SEQ_WIDTH     = 4,
  localparam int X_W   = (MAX_ROUTERS_X > 1) ? $clog2(MAX_ROUTERS_X) : 1,
  localparam int Y_W   = (MAX_ROUTERS_Y > 1) ? $clog2(MAX_ROUTERS_Y) : 1,
  localparam int CNT_W = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic                  s_tlast,
  input  logic [X_W-1:0]        dest_x,
  input  logic [Y_W-1:0]        dest_y,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast,
  output logic                  busy
);

  localparam int HDR_W = 2 * X_W + 2 * Y_W + 1 + SEQ_WIDTH;

  if (HDR_W > DATA_WIDTH) begin : g_hdr_check
    $error("noc_packetizer: header fields (%0d bits) exceed DATA_WIDTH (%0d)", HDR_W, DATA_WIDTH);
  end

  typedef enum logic [1:0] {
    IDLE,
    PAYLOAD,
    CONT
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     beat_cnt;
  logic [SEQ_WIDTH-1:0] seq;
  logic [X_W-1:0]       dest_x_r;
  logic [Y_W-1:0]       dest_y_r;
  logic                 out_free;
  logic                 cnt_last;

  // Header layout, LSB first: dest_x, dest_y, src_x, src_y, cont, seq; upper bits zero.
  function automatic logic [DATA_WIDTH-1:0] make_header(
    input logic [X_W-1:0]       dx,
    input logic [Y_W-1:0]       dy,
    input logic                 cont,
    input logic [SEQ_WIDTH-1:0] sq
  );
    logic [HDR_W-1:0] fields;
    fields = {sq, cont, Y_W'(ROUTER_Y), X_W'(ROUTER_X), dy, dx};
    return DATA_WIDTH'(fields);
  endfunction

  assign out_free = !m_tvalid || m_tready;
  assign cnt_last = (beat_cnt == CNT_W'(MAX_PAYLOAD - 1));
  assign s_tready = (state == PAYLOAD) && out_free;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      beat_cnt <= '0;
      seq      <= '0;
      dest_x_r <= '0;
      dest_y_r <= '0;
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
      m_tlast  <= 1'b0;
    end else begin
      // A consumed flit drops valid unless a new flit is loaded below.
      if (m_tvalid && m_tready) begin
        m_tvalid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (s_tvalid && out_free) begin
            m_tdata  <= make_header(dest_x, dest_y, 1'b0, '0);
            m_tlast  <= 1'b0;
            m_tvalid <= 1'b1;
            dest_x_r <= dest_x;
            dest_y_r <= dest_y;
            seq      <= '0;
            beat_cnt <= '0;
            state    <= PAYLOAD;
          end
        end

        PAYLOAD: begin
          if (s_tvalid && out_free) begin
            m_tdata  <= s_tdata;
            m_tlast  <= s_tlast || cnt_last;
            m_tvalid <= 1'b1;
            if (s_tlast) begin
              state <= IDLE;
            end else if (cnt_last) begin
              seq   <= seq + SEQ_WIDTH'(1);
              state <= CONT;
            end else begin
              beat_cnt <= beat_cnt + CNT_W'(1);
            end
          end
        end

        CONT: begin
          if (out_free) begin
            m_tdata  <= make_header(dest_x_r, dest_y_r, 1'b1, seq);
            m_tlast  <= 1'b0;
            m_tvalid <= 1'b1;
            beat_cnt <= '0;
            state    <= PAYLOAD;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
